// File: rtl/mem_data_access_ctrl.sv
// mem_data_access_ctrl
//   MEM-stage data-bus controller sitting just upstream of the MEM/WB register.
//   Issues one load/store per MEM instruction on an SRAM-like data bus, holds the
//   request until the bus accepts it, returns load data (with a same-cycle bypass)
//   and stalls the pipeline while the access is in flight. An irq flush in the
//   middle of a transaction is absorbed by draining the outstanding response.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_en/mem_wr        access request from MEM and its direction (1 = store)
//   mem_size             0 = byte, 1 = half, 2 = word
//   mem_addr/mem_wdata   byte address and right-justified store data
//   irq                  flush of the MEM instruction
//   advance              MEM instruction leaves MEM this cycle
//   data_req/data_wr     bus request and direction
//   data_size/data_addr  bus size and address
//   data_wdata           store data replicated onto the byte lanes
//   data_addr_ok         bus accepted the request this cycle
//   data_data_ok         bus response (read data or write ack) this cycle
//   data_rdata           bus read data
//   mem_rdata            load data to the MEM/WB register
//   mem_stall            MEM must hold this cycle
//   stall_cnt            saturating count of cycles with mem_stall = 1
module mem_data_access_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_en,
   input  logic             mem_wr,
   input  logic [1:0]       mem_size,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic             irq,
   input  logic             advance,
   output logic             data_req,
   output logic             data_wr,
   output logic [1:0]       data_size,
   output logic [31:0]      data_addr,
   output logic [31:0]      data_wdata,
   input  logic             data_addr_ok,
   input  logic             data_data_ok,
   input  logic [31:0]      data_rdata,
   output logic [31:0]      mem_rdata,
   output logic             mem_stall,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] REQ        = 3'd1;
   localparam logic [2:0] WAIT       = 3'd2;
   localparam logic [2:0] DONE       = 3'd3;
   localparam logic [2:0] DRAIN_REQ  = 3'd4;
   localparam logic [2:0] DRAIN_WAIT = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Copy of a request flushed before acceptance; the bus must keep seeing the
   // same request until addr_ok even though MEM now holds another instruction.
   logic             hold_wr_q, hold_wr_d;
   logic [1:0]       hold_size_q, hold_size_d;
   logic [31:0]      hold_addr_q, hold_addr_d;
   logic [31:0]      hold_wdata_q, hold_wdata_d;

   logic in_idle, in_req, in_wait, in_done, in_dreq, in_dwait;
   logic new_req;
   logic hold_en;
   logic stall_raw;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;

   assign in_idle  = (state_q == IDLE);
   assign in_req   = (state_q == REQ);
   assign in_wait  = (state_q == WAIT);
   assign in_done  = (state_q == DONE);
   assign in_dreq  = (state_q == DRAIN_REQ);
   assign in_dwait = (state_q == DRAIN_WAIT);

   // A fresh request only leaves IDLE for an unflushed MEM access.
   assign new_req = in_idle & mem_en & ~irq;

   // Flushed while the request is still unaccepted: remember what was on the bus.
   assign hold_en = in_req & irq & ~data_addr_ok;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (new_req) begin
               state_d = data_addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            // Accepted in the flush cycle: the response still has to be drained.
            if (data_addr_ok) begin
               state_d = irq ? DRAIN_WAIT : WAIT;
            end else if (irq) begin
               state_d = DRAIN_REQ;
            end
         end
         WAIT: begin
            if (data_data_ok) begin
               state_d = (irq || advance) ? IDLE : DONE;
            end else if (irq) begin
               state_d = DRAIN_WAIT;
            end
         end
         DONE: begin
            if (advance || irq) begin
               state_d = IDLE;
            end
         end
         DRAIN_REQ: begin
            if (data_addr_ok) begin
               state_d = DRAIN_WAIT;
            end
         end
         DRAIN_WAIT: begin
            if (data_data_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Load data is captured only for an unflushed response; drained data is dropped.
   always_comb begin
      rdata_d = rdata_q;
      if (in_wait && data_data_ok && !irq) begin
         rdata_d = data_rdata;
      end
   end

   always_comb begin
      hold_wr_d    = hold_wr_q;
      hold_size_d  = hold_size_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      if (hold_en) begin
         hold_wr_d    = mem_wr;
         hold_size_d  = mem_size;
         hold_addr_d  = mem_addr;
         hold_wdata_d = mem_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall generation and performance counter
   // ---------------------------------------------------------------------------
   // irq overrides everything: the flushed instruction must not hold the pipe.
   always_comb begin
      stall_raw = 1'b0;
      if (!irq) begin
         stall_raw = ((in_idle | in_req) & mem_en)
                   | (in_wait & ~data_data_ok)
                   | ((in_dreq | in_dwait) & mem_en);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_raw && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rdata_q      <= 32'h0;
         cnt_q        <= '0;
         hold_wr_q    <= 1'b0;
         hold_size_q  <= 2'd0;
         hold_addr_q  <= 32'h0;
         hold_wdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         hold_wr_q    <= hold_wr_d;
         hold_size_q  <= hold_size_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Bus outputs
   // ---------------------------------------------------------------------------
   assign req_size  = in_dreq ? hold_size_q  : mem_size;
   assign req_wdata = in_dreq ? hold_wdata_q : mem_wdata;

   assign data_wr   = in_dreq ? hold_wr_q   : mem_wr;
   assign data_addr = in_dreq ? hold_addr_q : mem_addr;
   assign data_size = req_size;

   // Replicate the right-justified store data onto every lane it can occupy.
   always_comb begin
      case (req_size)
         2'd0:    data_wdata = {4{req_wdata[7:0]}};
         2'd1:    data_wdata = {2{req_wdata[15:0]}};
         default: data_wdata = req_wdata;
      endcase
   end

   // Gated by rst_n so the bus sees no request while reset is asserted, even
   // with mem_en still high from an unreset upstream stage.
   assign data_req = rst_n & (new_req | in_req | in_dreq);

   // ---------------------------------------------------------------------------
   // Pipeline outputs
   // ---------------------------------------------------------------------------
   assign mem_rdata = (in_wait && data_data_ok) ? data_rdata : rdata_q;
   assign mem_stall = rst_n & stall_raw;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mem_data_access_ctrl.sv
// Testbench for mem_data_access_ctrl: directed scenarios followed by a random
// load/store stream against a memory-backed bus model and a reference memory.
module tb_mem_data_access_ctrl;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             mem_en, mem_wr, irq, advance;
   logic [1:0]       mem_size;
   logic [31:0]      mem_addr, mem_wdata;
   logic             data_req, data_wr;
   logic [1:0]       data_size;
   logic [31:0]      data_addr, data_wdata;
   logic             data_addr_ok, data_data_ok;
   logic [31:0]      data_rdata;
   logic [31:0]      mem_rdata;
   logic             mem_stall;
   logic [CNT_W-1:0] stall_cnt;

   // Bus inputs come either from the directed sequence or from the random slave.
   logic        slave_auto = 1'b0;
   logic        d_addr_ok, d_data_ok, s_addr_ok, s_data_ok;
   logic [31:0] d_rdata, s_rdata;
   assign data_addr_ok = slave_auto ? s_addr_ok : d_addr_ok;
   assign data_data_ok = slave_auto ? s_data_ok : d_data_ok;
   assign data_rdata   = slave_auto ? s_rdata   : d_rdata;

   mem_data_access_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_en       (mem_en),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .irq          (irq),
      .advance      (advance),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_rdata    (mem_rdata),
      .mem_stall    (mem_stall),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change at negedge+1, outputs are sampled at negedge+3.
   task automatic next();
      @(negedge clk);
      #1;
   endtask

   task automatic quiet();
      mem_en = 1'b0; irq = 1'b0; advance = 1'b0;
      d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = 32'h0;
   endtask

   task automatic present(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
      mem_en = 1'b1; mem_wr = wr; mem_size = size; mem_addr = addr; mem_wdata = wdata;
   endtask

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem[16];
   logic [31:0] slv_mem[16];
   logic        rnd_active = 1'b0;
   logic        new_instr = 1'b0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] size,
                                         input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      sh   = int'(off) * 8;
      mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      return (old & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // Bus slave: random accept/response latency, one outstanding transaction,
   // never addr_ok in the same cycle as data_ok.
   logic        pend = 1'b0;
   int          resp_dly;
   logic [31:0] pend_rdata;
   initial begin : bus_slave
      s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (!slave_auto || !rst_n) begin
            pend = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
         end else begin
            s_addr_ok = 1'b0;
            s_data_ok = 1'b0;
            if (pend) begin
               if (resp_dly == 0) begin
                  s_data_ok = 1'b1; s_rdata = pend_rdata; pend = 1'b0;
               end else begin
                  resp_dly--;
               end
            end else begin
               s_addr_ok = ($urandom_range(0, 2) != 0);
            end
            #3;
            if (s_addr_ok && data_req) begin
               pend     = 1'b1;
               resp_dly = $urandom_range(0, 2);
               if (data_wr) begin
                  for (int b = 0; b < 4; b++) begin
                     if ((data_size == 2'd2) ||
                         (data_size == 2'd1 && (b / 2) == int'(data_addr[1])) ||
                         (data_size == 2'd0 && b == int'(data_addr[1:0])))
                        slv_mem[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
                  end
                  pend_rdata = $urandom;
               end else begin
                  pend_rdata = slv_mem[data_addr[5:2]];
               end
            end
         end
      end
   end

   // Monitor: retires one scoreboard entry per commit (advance) or flush (irq).
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rnd_active && rst_n) begin
            if (!mem_en) begin
               check("gap_stall", 32'(mem_stall), 32'd0);
            end else begin
               if (new_instr && !irq) check("first_cycle_stall", 32'(mem_stall), 32'd1);
               if (irq || advance) begin
                  if (sb.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL sb_underflow: retire with empty scoreboard at %0t", $time);
                  end else begin
                     e = sb.pop_front();
                     check("retire_stall", 32'(mem_stall), 32'd0);
                     if (!irq && !e.wr) check("load_data", mem_rdata, e.data);
                  end
               end
            end
         end
      end
   end

   // One random instruction; entered and left at negedge+1.
   task automatic run_instr(output bit timed_out);
      logic        wr;
      logic [1:0]  size, off;
      logic [3:0]  idx;
      logic [31:0] wd, addr;
      bit          do_flush, done;
      int          flush_at, dly;
      exp_t        e;
      wr   = ($urandom_range(0, 9) < 4);
      size = 2'($urandom_range(0, 2));
      idx  = 4'($urandom_range(0, 15));
      off  = 2'($urandom_range(0, 3));
      if (size == 2'd1) off[0] = 1'b0;
      if (size == 2'd2) off = 2'd0;
      wd       = $urandom;
      addr     = 32'h1000_0000 | (32'(idx) << 2) | 32'(off);
      do_flush = !wr && ($urandom_range(0, 3) == 0);
      flush_at = $urandom_range(0, 3);
      dly      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      e.wr     = wr;
      e.data   = ref_mem[idx];
      if (wr) ref_mem[idx] = merge(ref_mem[idx], size, off, wd);
      sb.push_back(e);
      present(wr, size, addr, wd);
      new_instr = 1'b1;
      timed_out = 1'b0;
      done      = 1'b0;
      for (int cyc = 0; ; cyc++) begin
         #1;
         if (do_flush && cyc >= flush_at && mem_stall) begin
            irq = 1'b1; done = 1'b1;
         end else if (!mem_stall) begin
            if (dly == 0) begin
               advance = 1'b1; done = 1'b1;
            end else begin
               dly--;
            end
         end
         next();
         irq = 1'b0; advance = 1'b0; new_instr = 1'b0;
         if (done) break;
         if (cyc >= 60) begin
            checks++; errors++;
            $display("FAIL instr_timeout: no retire within 60 cycles at %0t", $time);
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin : main
      bit tmo;
      mem_wr = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
      quiet();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      #2;
      check("rst_req", 32'(data_req), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_cnt", 32'(stall_cnt), 32'd0);

      // 1: load word, addr_ok cycle 1, data_ok cycle 2, advance.
      next(); present(1'b0, 2'd2, 32'h8000_1000, 32'h0);
      #2 check("t1_c0_stall", 32'(mem_stall), 32'd1);
      check("t1_c0_req", 32'(data_req), 32'd1);
      check("t1_addr", data_addr, 32'h8000_1000);
      next(); d_addr_ok = 1'b1;
      #2 check("t1_c1_stall", 32'(mem_stall), 32'd1);
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hDEAD_BEEF; advance = 1'b1;
      #2 check("t1_c2_stall", 32'(mem_stall), 32'd0);
      check("t1_c2_rdata", mem_rdata, 32'hDEAD_BEEF);
      next(); quiet();
      #2 check("t1_held", mem_rdata, 32'hDEAD_BEEF);
      check("t1_cnt", 32'(stall_cnt), 32'd2);

      // 2: same load, advance withheld for 3 cycles after data_ok.
      next(); present(1'b0, 2'd2, 32'h8000_1000, 32'h0);
      #2 check("t2_idle_req", 32'(data_req), 32'd1);
      next(); d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hCAFE_F00D;
      #2 check("t2_bypass", mem_rdata, 32'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         next(); d_data_ok = 1'b0; d_rdata = 32'h5555_5555;
         #2 check("t2_done_rdata", mem_rdata, 32'hCAFE_F00D);
         check("t2_done_req", 32'(data_req), 32'd0);
         check("t2_done_stall", 32'(mem_stall), 32'd0);
      end
      next(); advance = 1'b1;
      #2 check("t2_leave_stall", 32'(mem_stall), 32'd0);
      next(); quiet();

      // 3: store byte 0xA5 to 0x3 with addr_ok withheld, then half and word stores.
      next(); present(1'b1, 2'd0, 32'h0000_0003, 32'h0000_00A5);
      for (int i = 0; i < 4; i++) begin
         #2 check("t3_req", 32'(data_req), 32'd1);
         check("t3_wdata", data_wdata, 32'hA5A5_A5A5);
         check("t3_wr", 32'(data_wr), 32'd1);
         check("t3_size", 32'(data_size), 32'd0);
         next();
      end
      d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; advance = 1'b1;
      next(); quiet(); present(1'b1, 2'd1, 32'h0000_0002, 32'h1234_BEEF); d_addr_ok = 1'b1;
      #2 check("t3_half_wdata", data_wdata, 32'hBEEF_BEEF);
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; advance = 1'b1;
      next(); quiet(); present(1'b1, 2'd2, 32'h0000_0004, 32'h1357_9BDF); d_addr_ok = 1'b1;
      #2 check("t3_word_wdata", data_wdata, 32'h1357_9BDF);
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; advance = 1'b1;
      next(); quiet();

      // 4: irq in WAIT, next instruction waits for the drain; late data dropped.
      next(); present(1'b0, 2'd2, 32'h8000_0010, 32'h0); d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'h600D_F00D; advance = 1'b1;
      next(); quiet(); present(1'b0, 2'd2, 32'h8000_0014, 32'h0); d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0; irq = 1'b1;
      #2 check("t4_irq_stall", 32'(mem_stall), 32'd0);
      next(); irq = 1'b0; present(1'b0, 2'd2, 32'h8000_2000, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin d_data_ok = 1'b1; d_rdata = 32'h0BAD_F00D; end
         #2 check("t4_drain_req", 32'(data_req), 32'd0);
         check("t4_drain_stall", 32'(mem_stall), 32'd1);
         check("t4_drain_rdata", mem_rdata, 32'h600D_F00D);
         next();
      end
      d_data_ok = 1'b0; d_rdata = 32'h0;
      #2 check("t4_after_req", 32'(data_req), 32'd1);
      check("t4_not_captured", mem_rdata, 32'h600D_F00D);
      d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'h1111_2222; advance = 1'b1;
      #2 check("t4_next_load", mem_rdata, 32'h1111_2222);
      next(); quiet();

      // 5: irq in REQ; request held until addr_ok, then drained.
      next(); present(1'b0, 2'd2, 32'h8000_0020, 32'h0);
      next(); irq = 1'b1;
      #2 check("t5_irq_req", 32'(data_req), 32'd1);
      check("t5_irq_stall", 32'(mem_stall), 32'd0);
      next(); irq = 1'b0; mem_en = 1'b0;
      #2 check("t5_dreq_req", 32'(data_req), 32'd1);
      check("t5_dreq_stall", 32'(mem_stall), 32'd0);
      next(); mem_en = 1'b1; d_addr_ok = 1'b1;
      #2 check("t5_dreq_en_stall", 32'(mem_stall), 32'd1);
      next(); d_addr_ok = 1'b0;
      #2 check("t5_dwait_req", 32'(data_req), 32'd0);
      check("t5_dwait_stall", 32'(mem_stall), 32'd1);
      next(); d_data_ok = 1'b1; d_rdata = 32'h7777_7777;
      #2 check("t5_drain_rdata", mem_rdata, 32'h1111_2222);
      next(); d_data_ok = 1'b0;
      #2 check("t5_idle_req", 32'(data_req), 32'd1);
      d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'h2468_1357; advance = 1'b1;
      #2 check("t5_next_load", mem_rdata, 32'h2468_1357);
      next(); quiet();

      // 6: reset in WAIT, then counter saturation while stuck in REQ.
      next(); present(1'b0, 2'd2, 32'h8000_0030, 32'h0); d_addr_ok = 1'b1;
      next(); d_addr_ok = 1'b0;
      #2 check("t6_wait_stall", 32'(mem_stall), 32'd1);
      rst_n = 1'b0;
      #1 check("t6_rst_req", 32'(data_req), 32'd0);
      check("t6_rst_stall", 32'(mem_stall), 32'd0);
      check("t6_rst_cnt", 32'(stall_cnt), 32'd0);
      check("t6_rst_rdata", mem_rdata, 32'd0);
      next(); rst_n = 1'b1;
      for (int k = 0; k <= 65541; k++) begin
         if (k != 0) next();
         #2;
         if (k == 0)     check("sat_start", 32'(stall_cnt), 32'd0);
         if (k == 100)   check("sat_100", 32'(stall_cnt), 32'd100);
         if (k == 65534) check("sat_edge", 32'(stall_cnt), 32'hFFFE);
         if (k == 65535) check("sat_full", 32'(stall_cnt), 32'hFFFF);
         if (k == 65541) check("sat_hold", 32'(stall_cnt), 32'hFFFF);
      end
      next(); rst_n = 1'b0; quiet();
      next(); rst_n = 1'b1;

      // Random stream.
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         slv_mem[i] = ref_mem[i];
      end
      slave_auto = 1'b1;
      rnd_active = 1'b1;
      for (int n = 0; n < 400; n++) begin
         run_instr(tmo);
         if (tmo) break;
         if ($urandom_range(0, 3) == 0) begin
            mem_en = 1'b0;
            next();
         end
      end
      mem_en = 1'b0;
      for (int i = 0; i < 20 && pend; i++) next();
      next();
      rnd_active = 1'b0;
      for (int i = 0; i < 16; i++) check("final_mem", slv_mem[i], ref_mem[i]);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
